softmax_exp_sequencer: RTL and testbench
========================================

# softmax_exp_sequencer

Initiator side of the `start_exp`/`exp_done` handshake for the softmax datapath. It buffers one score vector, finds its maximum, then drives the exp unit once per element with `x = score - max` (always ≤ 0), collecting each result and accumulating the running sum. The buffered exp values and their sum go downstream to the normalisation (divide) stage.

## Interface
- `VEC_LEN`, 8: maximum vector length (≥2).
- `INPUT_WIDTH`, 33: signed score and exp-argument width.
- `INPUT_FRAC_BITS`, 16: score fraction bits (pass-through; no rescaling).
- `EXP_WIDTH`, 16: exp result width (Q1.15).
- `SUM_WIDTH`, `EXP_WIDTH+$clog2(VEC_LEN)`: unsigned accumulator width.
- `TIMEOUT_CYCLES`, 64: watchdog limit; used only with the macro below.

Ports (clock and reset first):
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  score beat valid.
- `in_ready`  out  1  sequencer accepts scores.
- `in_data`  in  INPUT_WIDTH  signed score.
- `in_last`  in  1  final beat of vector.
- `start_exp`  out  1  one-cycle request pulse to exp unit.
- `x_out`  out  INPUT_WIDTH  exp argument, signed, ≤ 0.
- `exp_done`  in  1  one-cycle completion pulse from exp unit.
- `y_in`  in  EXP_WIDTH  signed exp result.
- `out_valid`  out  1  exp value beat valid.
- `out_ready`  in  1  downstream accepts beat.
- `out_data`  out  EXP_WIDTH  exp value, input order.
- `out_last`  out  1  final exp beat.
- `sum_out`  out  SUM_WIDTH  sum of all exp values in the vector.
- `sum_valid`  out  1  `sum_out` valid.
- `busy`  out  1  high in every state except LOAD.
- `err_timeout`  out  1  sticky watchdog flag.

## Operation
- FSM states: LOAD → ISSUE → WAIT → (ISSUE | DRAIN) → LOAD.
- LOAD:
  - `in_ready`=1; each handshake stores `in_data` at index `n` and updates the running max (first beat sets max).
  - Leave LOAD when `in_last` is accepted or the `VEC_LEN`-th beat is accepted. Extra beats are not accepted.
  - An `in_last` on the first beat gives `n`=1.
  - Index `i`=0 and the sum is cleared on exit.
- ISSUE:
  - `start_exp`=1 for exactly one cycle.
  - `x_out = sat(score[i] - max)`: the difference is computed in INPUT_WIDTH+1 bits and saturated to −2^(INPUT_WIDTH−1).
  - Next state is WAIT.
- WAIT:
  - `x_out` is held stable.
  - On `exp_done`, store `y_in` at index `i` after clamping negative values to 0, and add it to the sum. The sum saturates at 2^SUM_WIDTH−1.
  - Then `i++`; go to ISSUE if `i<n`, otherwise to DRAIN.
- `exp_done` outside WAIT, or in the same cycle as `start_exp`, is ignored.
- DRAIN:
  - `out_valid`=1 with `out_data`=exp[j]; `out_last`=1 when j=n−1.
  - `sum_valid`=1 and `sum_out` is stable throughout DRAIN.
  - The final handshake returns the FSM to LOAD.
  - `out_data` is held while `out_ready`=0.
- Reset values, asserted asynchronously:
  - All outputs 0, except `in_ready`=1 (LOAD).
  - `x_out`, `sum_out`, counters and `err_timeout` are 0.
  - Buffer contents are don't-care.
- Reset during ISSUE or WAIT drops the request. A late `exp_done` after reset arrives in LOAD and is ignored.

## Timing
- Vector load: `n` cycles at full input rate.
- Per element: 1 ISSUE cycle, then WAIT until `exp_done`. With a 5-cycle exp unit, ISSUE-to-next-ISSUE is 6 cycles.
- First `out_valid` occurs the cycle after the last `exp_done`.
- `in_ready` rises the cycle after the final output handshake.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `SOFTMAX_EXP_TIMEOUT_EN` defined:
  - A WAIT cycle counter is compiled in.
  - If `TIMEOUT_CYCLES` elapse with no `exp_done`, set `err_timeout` (sticky until `rst`), store 0 for that element, add nothing to the sum, and advance as if done.
- Not defined: WAIT blocks indefinitely, and `err_timeout` is tied to 0.

## Structure
- The shared softmax package holds:
  - the state enum (LOAD, ISSUE, WAIT, DRAIN);
  - the default width constants (33/16/16);
  - a `sat_sub` function for the saturating difference.
- One sub-module, `softmax_vec_buffer`: a dual-array register file (score array and exp array) with separate write ports and an indexed read. The FSM, max tracker and accumulator stay in the top module.

## Test plan
- Four scores of 0.0 (`in_last` on beat 4), bench exp model returns 32767 → `x_out`=0 four times; out beats are 32767 ×4 with `out_last` on beat 4; `sum_out`=131068.
- Scores {1.0, 0.5, 0.0, −1.0} → `x_out` = {0, −32768, −65536, −131072}; each `start_exp` is one cycle wide; `x_out` is stable until `exp_done`.
- Scores {−2^32, 2^32−1} → second-pass `x_out` for element 0 saturates to −2^32, with no wraparound.
- Exp model returns −5 for one element → stored and summed as 0; the other elements are unaffected.
- `out_ready` toggled 1/0 during DRAIN; `rst` pulsed mid-WAIT → data is held while stalled; reset returns the FSM to LOAD; the late `exp_done` is ignored; the next vector is correct.
- With `SOFTMAX_EXP_TIMEOUT_EN` and `exp_done` withheld 64 cycles on element 2 → `err_timeout`=1, that element's exp=0, the sequence completes; without the macro the FSM stays in WAIT.

Source files
------------

// File: rtl/softmax_exp_sequencer_pkg.sv
// Shared softmax types: sequencer state, default datapath widths and the
// saturating difference used to form exp arguments.
package softmax_exp_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DRAIN = 2'd3
    } seq_state_e;

    localparam int DEF_INPUT_WIDTH     = 33;
    localparam int DEF_INPUT_FRAC_BITS = 16;
    localparam int DEF_EXP_WIDTH       = 16;
    localparam int SAT_W               = 64;

    // Operands arrive sign-extended from w <= SAT_W-1 bits, so the 64-bit
    // difference is exact; the result is clamped to the signed w-bit range.
    function automatic logic signed [SAT_W-1:0] sat_sub(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int                      w
    );
        logic signed [SAT_W-1:0] diff;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        diff = a - b;
        hi   = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo   = -hi - 64'sd1;
        if (diff < lo) return lo;
        if (diff > hi) return hi;
        return diff;
    endfunction

endpackage

// File: rtl/softmax_exp_sequencer_vec_buffer.sv
// softmax_vec_buffer: score and exp register arrays with independent write
// ports and indexed reads. Contents are not reset.
module softmax_vec_buffer #(
    parameter int DEPTH = 8,
    parameter int SW    = 33,
    parameter int EW    = 16,
    parameter int IDXW  = 3
) (
    input  logic            clk,
    input  logic            score_we_i,
    input  logic [IDXW-1:0] score_waddr_i,
    input  logic [SW-1:0]   score_wdata_i,
    input  logic [IDXW-1:0] score_raddr_i,
    output logic [SW-1:0]   score_rdata_o,
    input  logic            exp_we_i,
    input  logic [IDXW-1:0] exp_waddr_i,
    input  logic [EW-1:0]   exp_wdata_i,
    input  logic [IDXW-1:0] exp_raddr_i,
    output logic [EW-1:0]   exp_rdata_o
);

    logic [DEPTH-1:0][SW-1:0] score_mem_q;
    logic [DEPTH-1:0][EW-1:0] exp_mem_q;

    always_ff @(posedge clk) begin
        if (score_we_i) score_mem_q[score_waddr_i] <= score_wdata_i;
        if (exp_we_i)   exp_mem_q[exp_waddr_i]     <= exp_wdata_i;
    end

    // Look-ahead addresses may run one past the end; those reads are unused.
    assign score_rdata_o = (32'(score_raddr_i) < DEPTH) ? score_mem_q[score_raddr_i] : '0;
    assign exp_rdata_o   = (32'(exp_raddr_i) < DEPTH)   ? exp_mem_q[exp_raddr_i]     : '0;

endmodule

// File: rtl/softmax_exp_sequencer.sv
// Softmax exp sequencer: buffers a score vector, tracks its max, drives the exp
// unit once per element and streams exp values plus their sum downstream.
// Optional WAIT watchdog: define SOFTMAX_EXP_TIMEOUT_EN.
module softmax_exp_sequencer
    import softmax_exp_sequencer_pkg::*;
#(
    parameter int VEC_LEN         = 8,
    parameter int INPUT_WIDTH     = DEF_INPUT_WIDTH,
    parameter int INPUT_FRAC_BITS = DEF_INPUT_FRAC_BITS,
    parameter int EXP_WIDTH       = DEF_EXP_WIDTH,
    parameter int SUM_WIDTH       = EXP_WIDTH + $clog2(VEC_LEN),
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INPUT_WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   start_exp,
    output logic [INPUT_WIDTH-1:0] x_out,
    input  logic                   exp_done,
    input  logic [EXP_WIDTH-1:0]   y_in,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_WIDTH-1:0]   out_data,
    output logic                   out_last,
    output logic [SUM_WIDTH-1:0]   sum_out,
    output logic                   sum_valid,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int IDXW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam int CNTW = $clog2(VEC_LEN + 1);
    localparam int SUMX = SUM_WIDTH + 1;

    generate
        if (VEC_LEN < 2 || INPUT_WIDTH > SAT_W - 1 || INPUT_FRAC_BITS >= INPUT_WIDTH ||
            TIMEOUT_CYCLES < 1 || SUM_WIDTH < EXP_WIDTH) begin : g_bad_cfg
            $error("softmax_exp_sequencer: illegal parameter set");
        end
    endgenerate

    seq_state_e                    state_q;
    logic [CNTW-1:0]               cnt_q, i_q, j_q;
    logic signed [INPUT_WIDTH-1:0] max_q;
    logic [SUM_WIDTH-1:0]          sum_q;
    logic [INPUT_WIDTH-1:0]        x_q;
    logic                          start_q, in_ready_q, busy_q;
    logic                          out_valid_q, out_last_q, sum_valid_q;
    logic [EXP_WIDTH-1:0]          out_data_q;

    logic                          in_fire, load_last, step, timed_out;
    logic signed [INPUT_WIDTH-1:0] max_d, issue_score, issue_max;
    logic [INPUT_WIDTH-1:0]        x_d, score_rd;
    logic [EXP_WIDTH-1:0]          y_clamp, step_val, exp_rd, first_exp;
    logic [SUMX-1:0]               sum_ext;
    logic [SUM_WIDTH-1:0]          sum_d;
    logic [CNTW-1:0]               i_nxt, j_nxt, last_idx;
    logic [IDXW-1:0]               score_raddr, exp_raddr;

`ifdef SOFTMAX_EXP_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TOW-1:0] wait_cnt_q;
    logic           err_q;
    assign timed_out   = (state_q == ST_WAIT) && !exp_done &&
                         (wait_cnt_q == TOW'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;
`else
    assign timed_out   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    assign in_fire   = in_valid && in_ready_q;
    assign load_last = in_fire && (in_last || cnt_q == CNTW'(VEC_LEN - 1));
    assign max_d     = (cnt_q == '0 || $signed(in_data) > max_q) ? $signed(in_data) : max_q;
    assign i_nxt     = i_q + CNTW'(1);
    assign j_nxt     = j_q + CNTW'(1);
    assign last_idx  = cnt_q - CNTW'(1);

    // The exp argument is formed one cycle early so it is registered together
    // with start_exp; on LOAD exit the first score/max may still be in flight.
    assign score_raddr = (state_q == ST_LOAD) ? '0 : IDXW'(i_nxt);
    assign issue_score = (state_q == ST_LOAD && cnt_q == '0) ? $signed(in_data) : $signed(score_rd);
    assign issue_max   = (state_q == ST_LOAD) ? max_d : max_q;
    assign x_d         = INPUT_WIDTH'(sat_sub(SAT_W'(issue_score), SAT_W'(issue_max), INPUT_WIDTH));

    assign step     = (state_q == ST_WAIT) && (exp_done || timed_out);
    assign y_clamp  = y_in[EXP_WIDTH-1] ? '0 : y_in;
    assign step_val = timed_out ? '0 : y_clamp;
    assign sum_ext  = {1'b0, sum_q} + SUMX'(step_val);
    assign sum_d    = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];

    // In WAIT the exp read port points at element 0 to prime the first output
    // beat; a single-element vector bypasses the value being written.
    assign exp_raddr = (state_q == ST_WAIT) ? '0 : IDXW'(j_nxt);
    assign first_exp = (i_q == '0) ? step_val : exp_rd;

    softmax_vec_buffer #(
        .DEPTH (VEC_LEN),
        .SW    (INPUT_WIDTH),
        .EW    (EXP_WIDTH),
        .IDXW  (IDXW)
    ) u_buf (
        .clk           (clk),
        .score_we_i    (in_fire),
        .score_waddr_i (IDXW'(cnt_q)),
        .score_wdata_i (in_data),
        .score_raddr_i (score_raddr),
        .score_rdata_o (score_rd),
        .exp_we_i      (step),
        .exp_waddr_i   (IDXW'(i_q)),
        .exp_wdata_i   (step_val),
        .exp_raddr_i   (exp_raddr),
        .exp_rdata_o   (exp_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            i_q         <= '0;
            j_q         <= '0;
            max_q       <= '0;
            sum_q       <= '0;
            x_q         <= '0;
            start_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            sum_valid_q <= 1'b0;
`ifdef SOFTMAX_EXP_TIMEOUT_EN
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (in_fire) begin
                        max_q <= max_d;
                        cnt_q <= cnt_q + CNTW'(1);
                        if (load_last) begin
                            state_q    <= ST_ISSUE;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            i_q        <= '0;
                            sum_q      <= '0;
                            start_q    <= 1'b1;
                            x_q        <= x_d;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
`ifdef SOFTMAX_EXP_TIMEOUT_EN
                    wait_cnt_q <= '0;
`endif
                end
                ST_WAIT: begin
                    if (step) begin
                        sum_q <= sum_d;
                        i_q   <= i_nxt;
                        if (i_nxt < cnt_q) begin
                            state_q <= ST_ISSUE;
                            start_q <= 1'b1;
                            x_q     <= x_d;
                        end else begin
                            state_q     <= ST_DRAIN;
                            j_q         <= '0;
                            out_valid_q <= 1'b1;
                            out_data_q  <= first_exp;
                            out_last_q  <= (cnt_q == CNTW'(1));
                            sum_valid_q <= 1'b1;
                        end
                    end
`ifdef SOFTMAX_EXP_TIMEOUT_EN
                    if (timed_out) err_q <= 1'b1;
                    if (!step) wait_cnt_q <= wait_cnt_q + TOW'(1);
`endif
                end
                ST_DRAIN: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_LOAD;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            sum_valid_q <= 1'b0;
                            in_ready_q  <= 1'b1;
                            busy_q      <= 1'b0;
                            cnt_q       <= '0;
                        end else begin
                            j_q        <= j_nxt;
                            out_data_q <= exp_rd;
                            out_last_q <= (j_nxt == last_idx);
                        end
                    end
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign start_exp = start_q;
    assign x_out     = x_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign sum_out   = sum_q;
    assign sum_valid = sum_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_softmax_exp_sequencer.sv
// Bench for softmax_exp_sequencer: directed and random vectors against a
// reference model of max/saturated difference/clamped exp/sum, plus an exp unit model.
module tb_softmax_exp_sequencer;

    localparam int VL = 8;
    localparam int IW = 33;
    localparam int EW = 16;
    localparam int SW = EW + $clog2(VL);

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, in_last;
    logic [IW-1:0] in_data;
    logic          start_exp;
    logic [IW-1:0] x_out;
    logic          exp_done = 1'b0;
    logic [EW-1:0] y_in = '0;
    logic          out_valid, out_ready, out_last;
    logic [EW-1:0] out_data;
    logic [SW-1:0] sum_out;
    logic          sum_valid, busy, err_timeout;

    always #5 clk = ~clk;

    softmax_exp_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .start_exp(start_exp), .x_out(x_out), .exp_done(exp_done), .y_in(y_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .sum_out(sum_out), .sum_valid(sum_valid), .busy(busy), .err_timeout(err_timeout)
    );

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // exp model: halves every 2^14 LSBs of distance below the max
    function automatic int exp_model(input longint x);
        longint k;
        k = (-x) >>> 14;
        if (k > 15) return 0;
        return 32767 >> k;
    endfunction

    // ---------------- exp unit model ----------------
    int                 resp_lat = 5, ovr_idx = -1, wh_idx = -1, elem = 0;
    logic signed [15:0] ovr_val = '0;
    bit                 pend = 0, pend_wh = 0, prev_wh = 0, chk_en = 1, prev_start = 0;
    int                 cnt = 0, prev_issue = -1, last_done_cyc = 0;
    logic [IW-1:0]      pend_x;
    logic [EW-1:0]      pend_y;
    longint             x_obs[$];

    always @(negedge clk) begin
        longint xs;
        exp_done = 1'b0;
        y_in     = EW'($urandom);
        if (pend && !start_exp) begin
            if (chk_en) chk("x_hold", $signed(x_out), $signed(pend_x));
            if (cnt > 0) cnt--;
            if (cnt == 0 && !pend_wh) begin
                exp_done      = 1'b1;
                y_in          = pend_y;
                pend          = 0;
                last_done_cyc = cyc;
            end
        end
        if (start_exp) begin
            xs = longint'($signed(x_out));
            if (chk_en) begin
                chk("start_width", prev_start, 0);
                if (prev_issue >= 0 && !prev_wh) chk("issue_gap", cyc - prev_issue, resp_lat + 1);
            end
            x_obs.push_back(xs);
            pend       = 1;
            pend_x     = x_out;
            cnt        = resp_lat;
            pend_wh    = (elem == wh_idx);
            pend_y     = (elem == ovr_idx) ? ovr_val : EW'(exp_model(xs));
            prev_issue = cyc;
            prev_wh    = pend_wh;
            elem++;
        end
        prev_start = start_exp;
    end

    // ---------------- reference model ----------------
    longint sc[VL];
    longint xe[VL];
    longint ye[VL];
    longint se;

    task automatic setup_exp(input int n, input int ovr, input logic signed [15:0] oval,
                             input int wh, input int lat);
        longint mx, lo, y;
        lo = -(longint'(1) <<< 32);
        mx = sc[0];
        for (int k = 1; k < n; k++) if (sc[k] > mx) mx = sc[k];
        se = 0;
        for (int k = 0; k < n; k++) begin
            xe[k] = sc[k] - mx;
            if (xe[k] < lo) xe[k] = lo;
            y = (k == ovr) ? longint'(oval) : longint'(exp_model(xe[k]));
            if (k == wh || y < 0) y = 0;
            ye[k] = y;
            se += y;
        end
        if (se > (longint'(1) <<< SW) - 1) se = (longint'(1) <<< SW) - 1;
        resp_lat = lat; ovr_idx = ovr; ovr_val = oval; wh_idx = wh;
        elem = 0; x_obs.delete(); prev_issue = -1; prev_wh = 0; chk_en = 1;
    endtask

    task automatic load_vec(input int n, input bit use_last);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = IW'(sc[k]);
            in_last  = use_last && (k == n - 1);
        end
        @(negedge clk);
        chk("busy_after_load", busy, 1);
        if (!use_last && n == VL) begin
            in_data = '1;
            in_last = 1'b1;
            chk("in_ready_full", in_ready, 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_check(input int n, input int mode);
        int k = 0;
        bit first = 1, stall = 0, rdy;
        logic [EW-1:0] held = '0;
        for (int t = 0; t < 4000 && k < n; t++) begin
            @(negedge clk);
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(t % 2) : bit'($urandom % 2);
            if (stall) chk("stall_hold", out_data, held);
            stall = 0;
            if (out_valid && first) begin
                first = 0;
                if (wh_idx != n - 1) chk("first_valid_lat", cyc, last_done_cyc + 1);
            end
            out_ready = rdy;
            if (out_valid) begin
                if (rdy) begin
                    chk("out_data", out_data, ye[k]);
                    chk("out_last", out_last, (k == n - 1) ? 1 : 0);
                    chk("sum_out", sum_out, se);
                    chk("sum_valid", sum_valid, 1);
                    k++;
                end else begin
                    stall = 1;
                    held  = out_data;
                end
            end
        end
        if (k < n) chk("drain_timeout", k, n);
        @(negedge clk);
        out_ready = 1'b0;
        chk("in_ready_rise", in_ready, 1);
        chk("busy_idle", busy, 0);
        chk("out_valid_idle", out_valid, 0);
        chk("x_count", x_obs.size(), n);
        for (int m = 0; m < n && m < x_obs.size(); m++) chk("x_out", x_obs[m], xe[m]);
    endtask

    task automatic run_vec(input int n, input bit use_last, input int mode, input int lat,
                           input int ovr, input logic signed [15:0] oval, input int wh);
        setup_exp(n, ovr, oval, wh, lat);
        load_vec(n, use_last);
        drain_check(n, mode);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_start"}, start_exp, 0);
        chk({tag, "_x_out"}, $signed(x_out), 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_sum_out"}, sum_out, 0);
        chk({tag, "_sum_valid"}, sum_valid, 0);
        chk({tag, "_err"}, err_timeout, 0);
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint r;
        int n;
        bit ul;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;

        // four zero scores, constant exp result
        for (int k = 0; k < 4; k++) sc[k] = 0;
        run_vec(4, 1, 0, 5, -1, 0, -1);
        chk("sum_131068", se, 131068);

        // 1.0, 0.5, 0.0, -1.0 in Q16
        sc[0] = 65536; sc[1] = 32768; sc[2] = 0; sc[3] = -65536;
        run_vec(4, 1, 0, 5, -1, 0, -1);

        // extreme scores: difference saturates to -2^32
        sc[0] = -(longint'(1) <<< 32); sc[1] = (longint'(1) <<< 32) - 1;
        run_vec(2, 1, 0, 3, -1, 0, -1);

        // negative exp result clamped to zero
        for (int k = 0; k < 4; k++) sc[k] = longint'($urandom_range(0, 200000)) - 100000;
        run_vec(4, 1, 0, 4, 1, -16'sd5, -1);

        // full vector without in_last, toggling out_ready
        for (int k = 0; k < VL; k++) sc[k] = longint'($urandom_range(0, 300000)) - 150000;
        run_vec(VL, 0, 1, 2, -1, 0, -1);

        // reset mid-WAIT, late exp_done ignored, next vector clean
        for (int k = 0; k < 4; k++) sc[k] = longint'(k) * 1000;
        setup_exp(4, -1, 0, -1, 20);
        load_vec(4, 1);
        repeat (3) @(negedge clk);
        chk("busy_in_wait", busy, 1);
        chk_en = 0;
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("midwait_reset");
        rst = 1'b0;
        for (int t = 0; t < 40 && pend; t++) @(negedge clk);
        chk("late_done_fired", pend, 0);
        @(negedge clk);
        chk("late_done_busy", busy, 0);
        chk("late_done_ready", in_ready, 1);
        chk("late_done_start", start_exp, 0);
        for (int k = 0; k < 3; k++) sc[k] = 5000 - longint'(k) * 7000;
        run_vec(3, 1, 2, 5, -1, 0, -1);

        // single-element vector
        sc[0] = -123456;
        run_vec(1, 1, 0, 1, -1, 0, -1);

        // exp_done withheld on element 2
        for (int k = 0; k < 4; k++) sc[k] = longint'(k) * 4096;
`ifdef SOFTMAX_EXP_TIMEOUT_EN
        run_vec(4, 1, 0, 3, -1, 0, 2);
        chk("err_timeout_set", err_timeout, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("err_timeout_clr", err_timeout, 0);
`else
        setup_exp(4, -1, 0, 2, 3);
        load_vec(4, 1);
        repeat (100) @(negedge clk);
        chk("wait_stuck_busy", busy, 1);
        chk("wait_stuck_outv", out_valid, 0);
        chk("wait_stuck_issues", x_obs.size(), 3);
        chk("wait_stuck_err", err_timeout, 0);
        chk_en = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        pend = 0;
        chk("stuck_reset_ready", in_ready, 1);
`endif

        // random vectors
        for (int v = 0; v < 12; v++) begin
            n  = $urandom_range(1, VL);
            ul = (n < VL) ? 1'b1 : bit'($urandom % 2);
            for (int k = 0; k < n; k++) begin
                if ($urandom % 4 == 0) begin
                    r = longint'({$urandom, $urandom});
                    sc[k] = (r <<< 31) >>> 31;
                end else begin
                    sc[k] = longint'($urandom_range(0, 400000)) - 200000;
                end
            end
            run_vec(n, ul, 2, $urandom_range(1, 6),
                    ($urandom % 3 == 0) ? int'($urandom_range(0, n - 1)) : -1,
                    -16'sd1 - 16'($urandom_range(0, 1000)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
